ramspnc_master: RTL and testbench

- Initiator for a single-port, no-change memory (en/we/addr/din in, registered dout, 1-cycle read latency, dout held on writes).
- Accepts burst commands on a valid/ready command channel and write data on a valid/ready write channel.
- Sequences one memory access per cycle and returns read data on a valid/ready response channel.
- A 2-entry response buffer absorbs the memory's read latency under backpressure, so no read data is ever lost.

---
 rtl/ramspnc_master_if.sv | 30 +++
 rtl/ramspnc_master.sv | 152 +++++++++++++++
 tb/tb_ramspnc_master.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramspnc_master_if.sv
// Command, write-data and read-response channels of the ramspnc_master.
// The host drives the master modport; the sequencer sits on the slave modport.
interface ramspnc_master_if #(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter int LW = 8
) ();
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last
  );
endinterface

// File: rtl/ramspnc_master.sv
// Burst sequencer for a single-port no-change RAM: one access per cycle,
// read data returned through a 2-entry buffer that covers the 1-cycle read latency.
module ramspnc_master #(
  parameter int DW = 16,
  parameter int AW = 10,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  ramspnc_master_if.slave bus,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          cmd_rdy;
  logic          wr_rdy;
  logic          en_c, we_c;
  logic          issue;

  logic          inflight_vld_p1;
  logic          inflight_last_p1;

  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_last;
  logic          wptr_q, rptr_q;
  logic [1:0]    fifo_cnt_q;
  logic          push, pop, rd_vld;
  logic [1:0]    occ;

  // Slots that will be held after this cycle if nothing new is issued.
  assign rd_vld = !rst && (fifo_cnt_q != 2'd0);
  assign pop    = rd_vld && bus.rd_ready;
  assign push   = inflight_vld_p1;
  assign occ    = fifo_cnt_q + {1'b0, inflight_vld_p1} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    cmd_rdy = 1'b0;
    wr_rdy  = 1'b0;
    en_c    = 1'b0;
    we_c    = 1'b0;
    issue   = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          cmd_rdy = 1'b1;
          if (bus.cmd_valid) begin
            addr_d  = bus.cmd_addr;
            len_d   = bus.cmd_len;
            cnt_d   = '0;
            state_d = bus.cmd_we ? WRITE : READ;
          end
        end
        WRITE: begin
          wr_rdy = 1'b1;
          if (bus.wr_valid) begin
            en_c   = 1'b1;
            we_c   = 1'b1;
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == len_q) state_d = IDLE;
          end
        end
        READ: begin
          if (occ < 2'd2) begin
            issue  = 1'b1;
            en_c   = 1'b1;
            addr_d = addr_q + 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == len_q) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage p1: read issued last cycle, memory data arrives now
  always_ff @(posedge clk) begin
    if (rst) inflight_vld_p1 <= 1'b0;
    else     inflight_vld_p1 <= issue;
  end

  always_ff @(posedge clk) begin
    inflight_last_p1 <= issue && (cnt_q == len_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      assert (!(push && !pop && fifo_cnt_q == 2'd2));
      if (push) wptr_q <= ~wptr_q;
      if (pop)  rptr_q <= ~rptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wptr_q] <= mem_dout;
      fifo_last[wptr_q] <= inflight_last_p1;
    end
  end

  assign bus.cmd_ready = cmd_rdy;
  assign bus.wr_ready  = wr_rdy;
  assign bus.rd_valid  = rd_vld;
  assign bus.rd_data   = rd_vld ? fifo_data[rptr_q] : '0;
  assign bus.rd_last   = rd_vld && fifo_last[rptr_q];

  assign mem_en   = en_c;
  assign mem_we   = we_c;
  assign mem_addr = addr_q;
  assign mem_din  = bus.wr_data;
  assign busy     = !rst && ((state_q != IDLE) || inflight_vld_p1 || (fifo_cnt_q != 2'd0));

endmodule

// File: tb/tb_ramspnc_master.sv
// Directed bench for ramspnc_master with a behavioural no-change RAM attached.
module tb_ramspnc_master;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ramspnc_master_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  ramspnc_master #(.DW(DW), .AW(AW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
  );

  // Single-port no-change RAM: dout updates only on reads
  logic [DW-1:0] ram [1<<AW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout <= ram[mem_addr];
    end
  end

  logic [AW-1:0] acc_addr [256];
  int n_acc = 0;
  int n_rd  = 0;
  always @(posedge clk) begin
    if (mem_en) begin
      acc_addr[n_acc % 256] <= mem_addr;
      n_acc <= n_acc + 1;
      if (!mem_we) n_rd <= n_rd + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    t = 0;
    while (!bus.cmd_ready && t < 40) begin
      step();
      t++;
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1 within 40 cycles", bus.cmd_ready);
    end
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = base + DW'(i);
      step();
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    step(); step(); step();
    n_tests++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, mem_en, mem_we, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: {cmd_rdy,wr_rdy,rd_vld,rd_last,en,we,busy}=%b required 0000000",
               {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, mem_en, mem_we, busy});
    end
    n_tests++;
    if (bus.rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %h required 0000", bus.rd_data);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_cmd_ready: got %b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_write_burst();
    int base;
    logic [AW-1:0] ea;
    base = n_acc;
    send_cmd(1'b1, 10'h010, 8'd3);
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'hA000 + 16'(i);
      ea = 10'h010 + 10'(i);
      #1;
      n_tests++;
      if ({bus.wr_ready, mem_en, mem_we} !== 3'b111 || mem_addr !== ea || mem_din !== 16'hA000 + 16'(i)) begin
        n_fail++;
        $display("FAIL write_beat%0d: rdy/en/we=%b addr=%h din=%h required 111 %h %h",
                 i, {bus.wr_ready, mem_en, mem_we}, mem_addr, mem_din, ea, 16'hA000 + 16'(i));
      end
      step();
    end
    bus.wr_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || mem_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL write_done: cmd_ready=%b mem_en=%b busy=%b required 1 0 0", bus.cmd_ready, mem_en, busy);
    end
    n_tests++;
    if (n_acc - base !== 4) begin
      n_fail++;
      $display("FAIL write_access_count: got %0d required 4", n_acc - base);
    end
  endtask

  task automatic test_read_burst();
    logic exp_v;
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 8'd3);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) begin
        n_tests++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h010 + 10'(c - 1)) begin
          n_fail++;
          $display("FAIL read_issue%0d: en=%b we=%b addr=%h required 1 0 %h",
                   c, mem_en, mem_we, mem_addr, 10'h010 + 10'(c - 1));
        end
      end
      exp_v = (c >= 3 && c <= 6);
      n_tests++;
      if (bus.rd_valid !== exp_v) begin
        n_fail++;
        $display("FAIL read_valid_cycle%0d: got %b required %b", c, bus.rd_valid, exp_v);
      end else if (exp_v) begin
        n_tests++;
        if (bus.rd_data !== 16'hA000 + 16'(c - 3) || bus.rd_last !== (c == 6)) begin
          n_fail++;
          $display("FAIL read_data_cycle%0d: data=%h last=%b required %h %b",
                   c, bus.rd_data, bus.rd_last, 16'hA000 + 16'(c - 3), (c == 6));
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int rbase, k, cyc;
    send_cmd(1'b1, 10'h100, 8'd7);
    write_beats(8, 16'hB000);
    bus.rd_ready = 1'b0;
    rbase = n_rd;
    send_cmd(1'b0, 10'h100, 8'd7);
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 80) begin
      bus.rd_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      n_tests++;
      if ((n_rd - rbase) - k > 2) begin
        n_fail++;
        $display("FAIL bp_outstanding cycle%0d: %0d reads outstanding, limit 2", cyc, (n_rd - rbase) - k);
      end
      if (bus.rd_valid && bus.rd_ready) begin
        n_tests++;
        if (bus.rd_data !== 16'hB000 + 16'(k) || bus.rd_last !== (k == 7)) begin
          n_fail++;
          $display("FAIL bp_beat%0d: data=%h last=%b required %h %b",
                   k, bus.rd_data, bus.rd_last, 16'hB000 + 16'(k), (k == 7));
        end
        k++;
      end
      step();
      cyc++;
    end
    n_tests++;
    if (k !== 8) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d required 8", k);
    end
    n_tests++;
    if (bus.rd_valid !== 1'b0 || busy !== 1'b0 || n_rd - rbase !== 8) begin
      n_fail++;
      $display("FAIL bp_drained: rd_valid=%b busy=%b reads=%0d required 0 0 8", bus.rd_valid, busy, n_rd - rbase);
    end
    bus.rd_ready = 1'b1;
  endtask

  task automatic test_wrap();
    int base, k, t;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    base = n_acc;
    send_cmd(1'b1, 10'h3FE, 8'd3);
    write_beats(4, 16'hC000);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (acc_addr[(base + i) % 256] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL wrap_addr%0d: got %h required %h", i, acc_addr[(base + i) % 256], exp_a[i]);
      end
    end
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h3FE, 8'd3);
    k = 0;
    t = 0;
    while (k < 4 && t < 20) begin
      if (bus.rd_valid) begin
        n_tests++;
        if (bus.rd_data !== 16'hC000 + 16'(k)) begin
          n_fail++;
          $display("FAIL wrap_readback%0d: got %h required %h", k, bus.rd_data, 16'hC000 + 16'(k));
        end
        k++;
      end
      step();
      t++;
    end
    n_tests++;
    if (k !== 4) begin
      n_fail++;
      $display("FAIL wrap_readback_count: got %0d required 4", k);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 10'h010, 8'd5);
    step();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_access: mem_en=%b required 0", mem_en);
    end
    step();
    n_tests++;
    if ({bus.rd_valid, busy, mem_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrst_state: rd_valid/busy/mem_en=%b required 000", {bus.rd_valid, busy, mem_en});
    end
    rst = 1'b0;
    step();
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 10'h010, 8'd0);
    t = 0;
    while (!bus.rd_valid && t < 10) begin
      step();
      t++;
    end
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hA000 || bus.rd_last !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_fresh_read: valid=%b data=%h last=%b required 1 a000 1",
               bus.rd_valid, bus.rd_data, bus.rd_last);
    end
    step();
  endtask

  task automatic test_gapped_write();
    int base;
    base = n_acc;
    send_cmd(1'b1, 10'h020, 8'd0);
    for (int g = 0; g < 2; g++) begin
      bus.wr_valid = 1'b0;
      #1;
      n_tests++;
      if (bus.wr_ready !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL gap%0d: wr_ready=%b en=%b we=%b required 1 0 0", g, bus.wr_ready, mem_en, mem_we);
      end
      step();
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'hD00D;
    #1;
    n_tests++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 10'h020 || mem_din !== 16'hD00D) begin
      n_fail++;
      $display("FAIL gap_beat: en/we=%b addr=%h din=%h required 11 020 d00d", {mem_en, mem_we}, mem_addr, mem_din);
    end
    step();
    bus.wr_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || n_acc - base !== 1) begin
      n_fail++;
      $display("FAIL gap_done: cmd_ready=%b accesses=%0d required 1 1", bus.cmd_ready, n_acc - base);
    end
  endtask

  task automatic test_back_to_back();
    int k, t;
    bus.rd_ready = 1'b0;
    send_cmd(1'b0, 10'h010, 8'd1);
    send_cmd(1'b0, 10'h012, 8'd1);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy: got %b required 1", busy);
    end
    bus.rd_ready = 1'b1;
    k = 0;
    t = 0;
    while (k < 4 && t < 30) begin
      if (bus.rd_valid) begin
        n_tests++;
        if (bus.rd_data !== 16'hA000 + 16'(k) || bus.rd_last !== (k == 1 || k == 3)) begin
          n_fail++;
          $display("FAIL b2b_beat%0d: data=%h last=%b required %h %b",
                   k, bus.rd_data, bus.rd_last, 16'hA000 + 16'(k), (k == 1 || k == 3));
        end
        k++;
      end
      step();
      t++;
    end
    n_tests++;
    if (k !== 4 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_count: beats=%0d rd_valid=%b required 4 0", k, bus.rd_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_gapped_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
